adsr_bank: RTL

Parametrised multi-voice ADSR envelope bank; successor to the fixed 16-voice, multi-clock envelope top level.
- Runs every voice from one system clock, gated by a sample-rate strobe; the separate attack, decay and release clocks are gone.
- Rates and sustain are run-time programmable. Retrigger is legato. Per-voice outputs are scaled, and a summed mix output is added.
- Sits between the oscillator bank and the audio output serialiser.

---
 rtl/adsr_pkg.sv | 22 ++
 rtl/adsr_voice.sv | 125 ++++++++++++
 rtl/adsr_bank.sv | 86 ++++++++
 3 files changed

// File: rtl/adsr_pkg.sv
// adsr_pkg: shared types and helpers for the ADSR envelope bank.
//   adsr_state_e : per-voice envelope state encoding (3 bits)
//   clog2        : ceil(log2(n)) for sizing the mix accumulator
package adsr_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } adsr_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/adsr_voice.sv
// adsr_voice: one envelope generator plus its output scaler.
//   gclk, grst_n  : clock, async active-low reset
//   tick          : sample strobe; state/env/gate/wave update only here
//   gate          : note gate for this voice
//   *_step,
//   sustain_level : live rate/sustain controls
//   prod_ld       : load the scaled product (cycle after a tick)
//   wave_in       : signed sample in; wave_out : enveloped sample
//   active        : voice is not IDLE
module adsr_voice
  import adsr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ENV_W = 16
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             tick,
  input  logic             gate,
  input  logic             prod_ld,
  input  logic [ENV_W-1:0] attack_step,
  input  logic [ENV_W-1:0] decay_step,
  input  logic [ENV_W-1:0] release_step,
  input  logic [ENV_W-1:0] sustain_level,
  input  logic [WIDTH-1:0] wave_in,
  output logic [WIDTH-1:0] wave_out,
  output logic             active
);

  localparam logic [ENV_W-1:0] FULL = '1;

  adsr_state_e             state_d, state_q, eff;
  logic        [ENV_W-1:0] env_d, env_q;
  logic                    gate_prev_d, gate_prev_q;
  logic signed [WIDTH-1:0] wave_d, wave_q;
  logic        [WIDTH-1:0] prod_d, prod_q;

  // One extra bit catches attack overflow / decay and release underflow.
  logic [ENV_W:0] att_sum, dec_diff, rel_diff;
  assign att_sum  = {1'b0, env_q} + {1'b0, attack_step};
  assign dec_diff = {1'b0, env_q} - {1'b0, decay_step};
  assign rel_diff = {1'b0, env_q} - {1'b0, release_step};

  always_comb begin
    state_d     = state_q;
    env_d       = env_q;
    gate_prev_d = gate_prev_q;
    wave_d      = wave_q;
    eff         = state_q;
    if (tick) begin
      gate_prev_d = gate;
      wave_d      = wave_in;
      // Gate edges pick the state whose arithmetic runs this same tick;
      // env is never cleared on retrigger, so attack resumes from where it is.
      if (gate && !gate_prev_q)
        eff = S_ATTACK;
      else if (!gate && (state_q == S_ATTACK || state_q == S_DECAY ||
                         state_q == S_SUSTAIN))
        eff = S_RELEASE;
      state_d = eff;
      case (eff)
        S_ATTACK: begin
          if (attack_step == '0 || att_sum[ENV_W] || att_sum[ENV_W-1:0] == FULL) begin
            env_d   = FULL;
            state_d = S_DECAY;
          end else begin
            env_d = att_sum[ENV_W-1:0];
          end
        end
        S_DECAY: begin
          if (decay_step == '0 || dec_diff[ENV_W] ||
              dec_diff[ENV_W-1:0] <= sustain_level) begin
            env_d   = sustain_level;
            state_d = S_SUSTAIN;
          end else begin
            env_d = dec_diff[ENV_W-1:0];
          end
        end
        S_SUSTAIN: env_d = sustain_level;
        S_RELEASE: begin
          if (release_step == '0 || rel_diff[ENV_W] || rel_diff[ENV_W-1:0] == '0) begin
            env_d   = '0;
            state_d = S_IDLE;
          end else begin
            env_d = rel_diff[ENV_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Envelope is treated as an unsigned fraction of 2^ENV_W; the zero pad
  // keeps it positive in the signed multiply.
  logic signed [WIDTH+ENV_W:0] prod_full;
  assign prod_full = wave_q * $signed({1'b0, env_q});

  logic unused_prod;
  assign unused_prod = ^{prod_full[WIDTH+ENV_W], prod_full[ENV_W-1:0]};

  always_comb begin
    prod_d = prod_q;
    if (prod_ld) prod_d = prod_full[ENV_W +: WIDTH];
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q     <= S_IDLE;
      env_q       <= '0;
      gate_prev_q <= 1'b0;
      wave_q      <= '0;
      prod_q      <= '0;
    end else begin
      state_q     <= state_d;
      env_q       <= env_d;
      gate_prev_q <= gate_prev_d;
      wave_q      <= wave_d;
      prod_q      <= prod_d;
    end
  end

  assign wave_out = prod_q;
  assign active   = (state_q != S_IDLE);

endmodule

// File: rtl/adsr_bank.sv
// adsr_bank: VOICES parallel ADSR envelopes on one clock, sample-strobed.
//   CLOCK12M, RESET : system clock, async active-low reset
//   sample_tick     : one-cycle sample strobe
//   note_on         : per-voice gates
//   attack/decay/release_step, sustain_level : shared live controls
//   wave_in/wave_out: flattened signed samples, voice i at [i*WIDTH +: WIDTH]
//   out_valid       : wave_out refreshed (tick + 2)
//   mix_out/mix_valid : sign-extended sum of wave_out (tick + 3)
//   env_active      : per-voice not-IDLE
module adsr_bank
  import adsr_pkg::*;
#(
  parameter int VOICES = 16,
  parameter int WIDTH  = 16,
  parameter int ENV_W  = 16
) (
  input  logic                             CLOCK12M,
  input  logic                             RESET,
  input  logic                             sample_tick,
  input  logic [VOICES-1:0]                note_on,
  input  logic [ENV_W-1:0]                 attack_step,
  input  logic [ENV_W-1:0]                 decay_step,
  input  logic [ENV_W-1:0]                 release_step,
  input  logic [ENV_W-1:0]                 sustain_level,
  input  logic [VOICES*WIDTH-1:0]          wave_in,
  output logic [VOICES*WIDTH-1:0]          wave_out,
  output logic                             out_valid,
  output logic [WIDTH+clog2(VOICES)-1:0]   mix_out,
  output logic                             mix_valid,
  output logic [VOICES-1:0]                env_active
);

  localparam int MW     = WIDTH + clog2(VOICES);
  localparam int STAGES = 2;

  // [0]: env registered, [1]: product registered, [2]: mix registered
  logic [STAGES:0] vld_pipe_d, vld_pipe_q;
  assign vld_pipe_d = {vld_pipe_q[STAGES-1:0], sample_tick};

  logic [VOICES-1:0][WIDTH-1:0] wave_in_v, wave_out_v;
  assign wave_in_v = wave_in;
  assign wave_out  = wave_out_v;

  for (genvar i = 0; i < VOICES; i++) begin : g_voice
    adsr_voice #(.WIDTH(WIDTH), .ENV_W(ENV_W)) u_voice (
      .gclk         (CLOCK12M),
      .grst_n       (RESET),
      .tick         (sample_tick),
      .gate         (note_on[i]),
      .prod_ld      (vld_pipe_q[0]),
      .attack_step  (attack_step),
      .decay_step   (decay_step),
      .release_step (release_step),
      .sustain_level(sustain_level),
      .wave_in      (wave_in_v[i]),
      .wave_out     (wave_out_v[i]),
      .active       (env_active[i])
    );
  end

  // clog2(VOICES) guard bits make the sum overflow-free.
  logic signed [MW-1:0] mix_d, mix_q;
  always_comb begin
    mix_d = mix_q;
    if (vld_pipe_q[1]) begin
      mix_d = '0;
      for (int i = 0; i < VOICES; i++)
        mix_d = mix_d + MW'($signed(wave_out_v[i]));
    end
  end

  always_ff @(posedge CLOCK12M or negedge RESET) begin
    if (!RESET) begin
      vld_pipe_q <= '0;
      mix_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      mix_q      <= mix_d;
    end
  end

  assign out_valid = vld_pipe_q[1];
  assign mix_valid = vld_pipe_q[2];
  assign mix_out   = mix_q;

endmodule
